// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the instruction
// fetch port and the load/store port, with a fixed memory read latency.
module mem_arbiter #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 22,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  owner_t            last_q, last_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_win, d_win;

  // Grants are gated by rst so every output reads 0 while reset is held.
  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    if (rst && state_q == S_IDLE) begin
      if (if_req && (!d_req || last_q == OWN_D)) if_win = 1'b1;
      else if (d_req)                            d_win  = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (if_win || d_win) begin
          owner_d  = if_win ? OWN_IF : OWN_D;
          last_d   = if_win ? OWN_IF : OWN_D;
          addr_d   = if_win ? if_addr : d_addr;
          we_d     = d_win & d_we;
          wdata_d  = if_win ? '0 : d_wdata;
          mem_en_d = 1'b1;
          mem_we_d = d_win & d_we;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q == OWN_IF) begin
            if_rvalid_d = 1'b1;
            if (!we_q) if_rdata_d = mem_rdata;
          end else begin
            d_rvalid_d = 1'b1;
            if (!we_q) d_rdata_d = mem_rdata;
          end
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_q      <= OWN_D;
      owner_q     <= OWN_IF;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_gnt    = if_win;
  assign d_gnt     = d_win;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign stall     = rst & ((state_q != S_IDLE) | (if_req & ~if_win) | (d_req & ~d_win));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a cycle model predicts grants, memory
// strobes and returned data; a second instance covers the one-cycle latency.
module tb_mem_arbiter;

  localparam int AW  = 22;
  localparam int DW  = 22;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we, stall;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall)
  );

  logic          rst1;
  logic          if_req1, if_gnt1, if_rvalid1, d_req1, d_we1, d_gnt1, d_rvalid1;
  logic [AW-1:0] if_addr1, d_addr1, mem_addr1;
  logic [DW-1:0] if_rdata1, d_wdata1, d_rdata1, mem_wdata1, mem_rdata1;
  logic          mem_en1, mem_we1, stall1;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst1),
    .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1),
    .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .stall(stall1)
  );

  assign mem_rdata1 = mem_addr1 ^ 22'h155555;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    bit            port;   // 1 = data port
    int            cyc;
    logic [DW-1:0] data;
  } sb_t;

  sb_t           sb[$];
  sb_t           mon_e;
  logic [DW-1:0] mmem [logic [AW-1:0]];
  int            cyc = 0;
  bit            m_last = 1'b1;
  int            m_free = 0;
  int            m_issue = -1;
  logic [AW-1:0] m_addr = '0;
  bit            m_we = 1'b0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_if_rd = '0, m_d_rd = '0;
  int            rd_cd = -1;
  logic [AW-1:0] rd_addr = '0;
  bit            m_idle, e_if, e_d, e_ifv, e_dv;
  int            dut_if_n = 0, dut_d_n = 0;
  bit            seen_bad = 1'b0;
  bit            lat1_done = 1'b0;

  function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
    if (mmem.exists(a)) return mmem[a];
    return a ^ 22'h2AAAAA;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model, memory responder and scoreboard, all evaluated mid-cycle.
  always @(negedge clk) begin
    mem_rdata = DW'($urandom);
    if (!rst) begin
      sb.delete();
      m_last = 1'b1; m_free = 0; m_issue = -1; rd_cd = -1;
      m_if_rd = '0; m_d_rd = '0;
    end else begin
      if (rd_cd > 0) begin
        rd_cd--;
        if (rd_cd == 0) begin
          mem_rdata = mread(rd_addr);
          rd_cd = -1;
        end
      end
      if (mem_en && mem_addr == 22'h0ABCDE) seen_bad = 1'b1;
      if (if_gnt) dut_if_n++;
      if (d_gnt)  dut_d_n++;

      m_idle = (cyc >= m_free);
      e_if   = m_idle && if_req && (!d_req || m_last);
      e_d    = m_idle && d_req && !e_if;
      check("if_gnt", if_gnt, e_if);
      check("d_gnt", d_gnt, e_d);
      check("stall", stall, !m_idle || (if_req && !e_if) || (d_req && !e_d));
      check("mem_en", mem_en, cyc == m_issue);
      check("mem_we", mem_we, cyc == m_issue && m_we);
      if (cyc == m_issue) begin
        check("mem_addr", mem_addr, m_addr);
        if (m_we) check("mem_wdata", mem_wdata, m_wdata);
        rd_addr = m_addr;
        rd_cd   = LAT;
      end

      e_ifv = sb.size() > 0 && sb[0].cyc == cyc && !sb[0].port;
      e_dv  = sb.size() > 0 && sb[0].cyc == cyc &&  sb[0].port;
      check("if_rvalid", if_rvalid, e_ifv);
      check("d_rvalid", d_rvalid, e_dv);
      if (e_ifv || e_dv) begin
        mon_e = sb.pop_front();
        if (mon_e.port) m_d_rd = mon_e.data;
        else            m_if_rd = mon_e.data;
      end
      check("if_rdata", if_rdata, m_if_rd);
      check("d_rdata", d_rdata, m_d_rd);

      if (e_if || e_d) begin
        m_addr  = e_d ? d_addr : if_addr;
        m_we    = e_d && d_we;
        m_wdata = d_wdata;
        mon_e.port = e_d;
        mon_e.cyc  = cyc + LAT + 2;
        mon_e.data = m_we ? m_d_rd : mread(m_addr);
        if (m_we) mmem[m_addr] = d_wdata;
        sb.push_back(mon_e);
        m_issue = cyc + 1;
        m_free  = cyc + LAT + 2;
        m_last  = e_d;
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_if_gnt"}, if_gnt, 0);
    check({tag, "_d_gnt"}, d_gnt, 0);
    check({tag, "_rvalid"}, {if_rvalid, d_rvalid}, 0);
    check({tag, "_rdata"}, if_rdata | d_rdata, 0);
    check({tag, "_mem_ctl"}, {mem_en, mem_we}, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_stall"}, stall, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic do_req(input bit is_d, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (is_d ? d_gnt : if_gnt) break;
    end
    check("req_granted", is_d ? d_gnt : if_gnt, 1);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!stall && sb.size() == 0) break;
    end
    check("idle_reached", stall, 0);
    @(posedge clk); #1;
  endtask

  initial begin : main
    int a_if, a_d;
    rst = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_we = 1'b0;
    mmem[22'h000004] = 22'h012345;
    if_req = 1'b1; d_req = 1'b1;
    repeat (2) @(posedge clk); #1;
    check_zero("reset");
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;

    do_req(1'b0, 1'b0, 22'h000004, '0);
    wait_idle();
    check("fetch_rdata", if_rdata, 22'h012345);
    check("fetch_d_rdata", d_rdata, 0);

    do_reset();
    a_if = dut_if_n; a_d = dut_d_n;
    if_addr = 22'h000010; d_addr = 22'h000020; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    repeat (13) @(posedge clk);
    #1 if_req = 1'b0; d_req = 1'b0;
    wait_idle();
    check("alt_if_grants", dut_if_n - a_if, 2);
    check("alt_d_grants", dut_d_n - a_d, 2);

    do_req(1'b1, 1'b1, 22'h000040, 22'h3FFFFF);
    wait_idle();
    check("store_keeps_d_rdata", d_rdata, 22'h000020 ^ 22'h2AAAAA);
    do_req(1'b1, 1'b0, 22'h000040, '0);
    wait_idle();
    check("store_readback", d_rdata, 22'h3FFFFF);

    d_req = 1'b1; d_addr = 22'h000030;
    @(posedge clk); #1;
    d_req = 1'b0; if_req = 1'b1; if_addr = 22'h0ABCDE;
    @(posedge clk); #1 if_req = 1'b0;
    wait_idle();
    check("dropped_if_no_access", seen_bad, 0);

    d_req = 1'b1; d_addr = 22'h000050;
    @(posedge clk); #1 d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; if_req = 1'b1; d_req = 1'b1;
    #1 check_zero("mid_wait_reset");
    @(posedge clk); #1 rst = 1'b1;
    a_if = dut_if_n; a_d = dut_d_n;
    @(posedge clk); #1 if_req = 1'b0; d_req = 1'b0;
    wait_idle();
    check("post_reset_if_first", dut_if_n - a_if, 1);
    check("post_reset_no_d", dut_d_n - a_d, 0);

    wait (lat1_done);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  // One-cycle latency: back-to-back fetches every third cycle, rvalid
  // coinciding with the next grant.
  initial begin : lat1
    rst1 = 1'b0; if_req1 = 1'b0; if_addr1 = 22'h000123;
    d_req1 = 1'b0; d_we1 = 1'b0; d_addr1 = '0; d_wdata1 = '0;
    repeat (2) @(posedge clk);
    #1 rst1 = 1'b1; if_req1 = 1'b1;
    for (int r = 0; r < 11; r++) begin
      @(negedge clk);
      check($sformatf("lat1_gnt_%0d", r), if_gnt1, (r % 3 == 0) && r <= 6);
      check($sformatf("lat1_rvalid_%0d", r), if_rvalid1, r == 3 || r == 6 || r == 9);
      check($sformatf("lat1_d_%0d", r), {d_gnt1, d_rvalid1}, 0);
      if (r == 3 || r == 6 || r == 9)
        check($sformatf("lat1_rdata_%0d", r), if_rdata1, 22'h155476);
      if (r == 6) begin
        @(posedge clk); #1 if_req1 = 1'b0;
      end
    end
    lat1_done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
